// File: rtl/arc4_crack_if.sv
// Handshake bundle between the key-search controller, its host and the
// ARC4 core whose plaintext write port it snoops.
interface arc4_crack_if;
    logic        en;
    logic        rdy;
    logic [23:0] key;
    logic        key_valid;
    logic        arc4_en;
    logic        arc4_rdy;
    logic [23:0] arc4_key;
    logic [7:0]  pt_addr;
    logic [7:0]  pt_wrdata;
    logic        pt_wren;

    // Environment side: host start request plus the core's status and write port.
    modport master (
        output en, arc4_rdy, pt_addr, pt_wrdata, pt_wren,
        input  rdy, key, key_valid, arc4_en, arc4_key
    );

    // Controller side.
    modport slave (
        input  en, arc4_rdy, pt_addr, pt_wrdata, pt_wren,
        output rdy, key, key_valid, arc4_en, arc4_key
    );
endinterface

// File: rtl/arc4_crack.sv
// Brute-force ARC4 key search controller. Starts the core on successive
// candidate keys and accepts the first key whose decrypted message is all
// printable ASCII, or reports the slice of key space as exhausted.
module arc4_crack #(
    parameter logic [23:0] KEY_START = 24'h000000,
    parameter logic [23:0] KEY_LAST  = 24'hFFFFFF,
    parameter logic [23:0] KEY_STEP  = 24'd1
) (
    input  logic         clk,
    input  logic         rst_n,
    arc4_crack_if.slave  bus
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_WAIT_BUSY = 3'd2;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;
    localparam logic [2:0] S_EVAL      = 3'd4;
    localparam logic [2:0] S_DONE      = 3'd5;

    logic [2:0]  state;
    logic [23:0] cand;
    logic        valid;
    logic [7:0]  len;
    logic        bad;
    logic [24:0] next_cand;
    logic        snoop_active;

    // The extra bit catches carry out of 24'hFFFFFF so the search never wraps.
    assign next_cand    = {1'b0, cand} + {1'b0, KEY_STEP};
    assign snoop_active = ((state == S_WAIT_BUSY) || (state == S_WAIT_DONE)) && bus.pt_wren;

    assign bus.rdy       = (state == S_IDLE) || (state == S_DONE);
    assign bus.key       = cand;
    assign bus.arc4_key  = cand;
    assign bus.key_valid = valid;
    // The start pulse lasts one cycle because START is left on the same edge.
    assign bus.arc4_en   = (state == S_START) && bus.arc4_rdy;

    // Search sequencing: candidate stepping and the final verdict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cand  <= '0;
            valid <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register updating from
            // pre-edge values, so statement order inside the block is irrelevant.
            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.en) begin
                        cand  <= KEY_START;
                        valid <= 1'b0;
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (bus.arc4_rdy) state <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (!bus.arc4_rdy) state <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (bus.arc4_rdy) state <= S_EVAL;
                end
                S_EVAL: begin
                    if (!bad) begin
                        valid <= 1'b1;
                        state <= S_DONE;
                    end else if (next_cand > {1'b0, KEY_LAST}) begin
                        valid <= 1'b0;
                        state <= S_DONE;
                    end else begin
                        cand  <= next_cand[23:0];
                        state <= S_START;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Plaintext snoop: byte 0 carries the length, bytes 1..len must be printable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len <= '0;
            bad <= 1'b0;
        end else if (state == S_START) begin
            len <= '0;
            bad <= 1'b0;
        end else if (snoop_active) begin
            if (bus.pt_addr == 8'd0) begin
                len <= bus.pt_wrdata;
            end else if ((bus.pt_addr <= len) &&
                         ((bus.pt_wrdata < 8'h20) || (bus.pt_wrdata > 8'h7E))) begin
                bad <= 1'b1;
            end
        end
    end

endmodule
